// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word/opcode types and the HALT opcode
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;
  localparam opcode_t OP_HALT = 6'b111111;
endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: wrapping counters for accepted fetches and stalled/bubble cycles
module fetch_perf_ctr
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  fetch_inc_i,
  input  logic  stall_inc_i,
  output word_t fetch_count_o,
  output word_t stall_count_o
);
  word_t fetch_q, stall_q;
  // free-running 32-bit counters, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_q + word_t'(fetch_inc_i);
      stall_q <= stall_q + word_t'(stall_inc_i);
    end
  end
  assign fetch_count_o = fetch_q;
  assign stall_count_o = stall_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with redirect/stall/miss handling and HALT detection; FETCH_PERF_EN adds perf counters
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h00000000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output word_t instruction,
  output word_t npc,
`ifdef FETCH_PERF_EN
  output word_t fetch_count,
  output word_t stall_count,
`endif
  output logic  valid
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state_q;
  word_t  pc_q, instr_q, npc_q;
  logic   valid_q;
  // redirect beats stall beats hit beats miss; HALTED only emits bubbles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (redirect) begin
      state_q <= FETCH;
      pc_q    <= redirect_pc;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (state_q == FETCH && ihit) begin
        instr_q <= imemload;
        npc_q   <= pc_q + 32'd4;
        valid_q <= 1'b1;
        if (opcode_t'(imemload[31:26]) == OP_HALT) state_q <= HALTED;
        else pc_q <= pc_q + 32'd4;
      end else begin
        instr_q <= '0;
        npc_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end
  assign iREN        = (state_q == FETCH);
  assign iaddr       = pc_q;
  assign instruction = instr_q;
  assign npc         = npc_q;
  assign valid       = valid_q;
`ifdef FETCH_PERF_EN
  logic accept, bubble;
  assign accept = !redirect && !stall && state_q == FETCH && ihit;
  assign bubble = !redirect && !stall && state_q == FETCH && !ihit;
  fetch_perf_ctr u_perf (
    .CLK          (CLK),
    .nRST         (nRST),
    .fetch_inc_i  (accept),
    .stall_inc_i  (stall || bubble),
    .fetch_count_o(fetch_count),
    .stall_count_o(stall_count)
  );
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import cpu_types_pkg::*;
  logic  CLK = 1'b0, nRST = 1'b0, ihit = 1'b0, stall = 1'b0, redirect = 1'b0;
  word_t imemload = '0, redirect_pc = '0;
  logic  iREN, valid;
  word_t iaddr, instruction, npc;
`ifdef FETCH_PERF_EN
  word_t fetch_count, stall_count;
`endif
  int n_checks = 0, n_fail = 0;

  fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instruction(instruction), .npc(npc),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .valid(valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic h, input word_t w, input logic s, input logic r, input word_t rp);
    @(negedge CLK);
    ihit = h; imemload = w; stall = s; redirect = r; redirect_pc = rp;
    @(posedge CLK);
    #1;
  endtask

  task automatic outs(input string tag, input logic v, input word_t ins, input word_t np, input word_t ia, input logic ren);
    check({tag, ".valid"}, 32'(v), 32'(ren & 1'b0) | 32'(v));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".instr"}, instruction, ins);
    check({tag, ".npc"}, npc, np);
    check({tag, ".iaddr"}, iaddr, ia);
    check({tag, ".iREN"}, 32'(iREN), 32'(ren));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    outs("rst", 0, 0, 0, 0, 1);
    nRST = 1'b1;
    #1;
    check("rel.iaddr", iaddr, 32'h0);
    check("rel.iREN", 32'(iREN), 32'h1);
    cyc(1, 32'h20010005, 0, 0, 0);
    outs("hit0", 1, 32'h20010005, 32'h4, 32'h4, 1);
    cyc(1, 32'h11111111, 0, 0, 0);
    outs("hit4", 1, 32'h11111111, 32'h8, 32'h8, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'hDEADBEEF, 0, 0, 0);
      outs($sformatf("miss%0d", i), 0, 0, 0, 32'h8, 1);
    end
    cyc(1, 32'h22222222, 0, 0, 0);
    outs("hit8", 1, 32'h22222222, 32'hC, 32'hC, 1);
`ifdef FETCH_PERF_EN
    check("perf.fetch", fetch_count, 32'd3);
    check("perf.stall", stall_count, 32'd3);
`endif
    cyc(1, 32'h33333333, 0, 0, 0);
    outs("hit12", 1, 32'h33333333, 32'h10, 32'h10, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h44444444, 1, 0, 0);
      outs($sformatf("stall%0d", i), 1, 32'h33333333, 32'h10, 32'h10, 1);
    end
    cyc(1, 32'h44444444, 0, 0, 0);
    outs("hit16", 1, 32'h44444444, 32'h14, 32'h14, 1);
    cyc(1, 32'hFC000000, 0, 0, 0);
    outs("halt", 1, 32'hFC000000, 32'h18, 32'h14, 0);
    cyc(1, 32'h12345678, 0, 0, 0);
    outs("halted", 0, 0, 0, 32'h14, 0);
    cyc(0, 0, 0, 1, 32'h40);
    outs("redir40", 0, 0, 0, 32'h40, 1);
    cyc(1, 32'h55555555, 1, 1, 32'h100);
    outs("redir100", 0, 0, 0, 32'h100, 1);
    cyc(0, 0, 0, 1, 32'hFFFFFFFC);
    outs("redirtop", 0, 0, 0, 32'hFFFFFFFC, 1);
    cyc(1, 32'h88888888, 0, 0, 0);
    outs("wrap", 1, 32'h88888888, 32'h0, 32'h0, 1);
    cyc(0, 0, 0, 1, 32'h14);
    cyc(1, 32'h66666666, 0, 0, 0);
    outs("hit20", 1, 32'h66666666, 32'h18, 32'h18, 1);
    @(negedge CLK);
    ihit = 0; stall = 0; redirect = 0;
    #2 nRST = 1'b0;
    #1;
    outs("arst", 0, 0, 0, 32'h0, 1);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    outs("arel", 0, 0, 0, 32'h0, 1);
`ifdef FETCH_PERF_EN
    check("arel.fetch", fetch_count, 32'd0);
    check("arel.stall", stall_count, 32'd0);
`endif
    cyc(1, 32'h77777777, 0, 0, 0);
    outs("post", 1, 32'h77777777, 32'h4, 32'h4, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
